// File: rtl/eth_mac_csr_init_arb_if.sv
`default_nettype none
// ============================================================================
// eth_mac_csr_init_arb_if: Avalon-MM CSR bus (10-bit word address, 32-bit data).
// Revision: 1.0
// ============================================================================
interface eth_mac_csr_init_arb_if;
  logic        read;
  logic        write;
  logic [9:0]  address;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        waitrequest;

  modport master (
    output read, write, address, writedata,
    input  readdata, waitrequest
  );

  modport slave (
    input  read, write, address, writedata,
    output readdata, waitrequest
  );
endinterface
`default_nettype wire

// File: rtl/eth_mac_csr_init_arb.sv
`default_nettype none
// ============================================================================
// eth_mac_csr_init_arb: writes a 4-entry CSR table into the 10G MAC after reset
// or init_start, then passes the host CSR port straight through to the MAC.
// Optional readback check of every entry: define CSR_INIT_VERIFY_EN.
// Revision: 1.0
// ============================================================================
module eth_mac_csr_init_arb #(
  parameter logic [9:0]  ADDR0          = 10'h000,
  parameter logic [31:0] DATA0          = 32'h0000_0003,
  parameter logic [9:0]  ADDR1          = 10'h001,
  parameter logic [31:0] DATA1          = 32'd1518,
  parameter logic [9:0]  ADDR2          = 10'h002,
  parameter logic [31:0] DATA2          = 32'd1518,
  parameter logic [9:0]  ADDR3          = 10'h003,
  parameter logic [31:0] DATA3          = 32'h0000_FFFF,
  parameter int          TIMEOUT_CYCLES = 1023
) (
  input  logic                          csr_clk_i,
  input  logic                          csr_rst_i,
  input  logic                          init_start_i,
  output logic                          init_done_o,
  output logic                          init_error_o,
  output logic [1:0]                    err_index_o,
  eth_mac_csr_init_arb_if.slave         host_if,
  eth_mac_csr_init_arb_if.master        mac_if
);

  typedef enum logic [2:0] {
    ST_WR   = 3'd0,
    ST_RD   = 3'd1,
    ST_CMP  = 3'd2,
    ST_NEXT = 3'd3,
    ST_PASS = 3'd4
  } state_e;

  localparam logic [9:0] C_TIMEOUT_LAST = 10'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [9:0]  tmo_q, tmo_d;
  logic        start_pend_q, start_pend_d;
  logic        wr_q, wr_d;
  logic        rd_q, rd_d;
  logic [9:0]  addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        err_q, err_d;
  logic [1:0]  err_idx_q, err_idx_d;
`ifdef CSR_INIT_VERIFY_EN
  logic [31:0] rdata_q, rdata_d;
`endif

  logic w_pass;
  logic w_start;
  logic w_host_busy;

  function automatic logic [9:0] tbl_addr(input logic [1:0] i);
    logic [9:0] a;
    case (i)
      2'd0:    a = ADDR0;
      2'd1:    a = ADDR1;
      2'd2:    a = ADDR2;
      default: a = ADDR3;
    endcase
    return a;
  endfunction

  function automatic logic [31:0] tbl_data(input logic [1:0] i);
    logic [31:0] d;
    case (i)
      2'd0:    d = DATA0;
      2'd1:    d = DATA1;
      2'd2:    d = DATA2;
      default: d = DATA3;
    endcase
    return d;
  endfunction

  assign w_pass      = (state_q == ST_PASS);
  assign w_start     = start_pend_q | init_start_i;
  assign w_host_busy = host_if.read | host_if.write;

  always_ff @(posedge csr_clk_i or posedge csr_rst_i) begin
    if (csr_rst_i) begin
      state_q      <= ST_WR;
      idx_q        <= 2'd0;
      tmo_q        <= 10'd0;
      start_pend_q <= 1'b0;
      wr_q         <= 1'b0;
      rd_q         <= 1'b0;
      addr_q       <= 10'd0;
      wdata_q      <= 32'd0;
      err_q        <= 1'b0;
      err_idx_q    <= 2'd0;
`ifdef CSR_INIT_VERIFY_EN
      rdata_q      <= 32'd0;
`endif
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      tmo_q        <= tmo_d;
      start_pend_q <= start_pend_d;
      wr_q         <= wr_d;
      rd_q         <= rd_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      err_q        <= err_d;
      err_idx_q    <= err_idx_d;
`ifdef CSR_INIT_VERIFY_EN
      rdata_q      <= rdata_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    tmo_d        = tmo_q;
    start_pend_d = start_pend_q | init_start_i;
    wr_d         = wr_q;
    rd_d         = rd_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    err_d        = err_q;
    err_idx_d    = err_idx_q;
`ifdef CSR_INIT_VERIFY_EN
    rdata_d      = rdata_q;
`endif

    case (state_q)
      ST_WR: begin
        // wr_q is only low here straight after reset: issue the first entry
        if (!wr_q) begin
          wr_d    = 1'b1;
          addr_d  = tbl_addr(idx_q);
          wdata_d = tbl_data(idx_q);
          tmo_d   = 10'd0;
        end else if (!mac_if.waitrequest) begin
          wr_d  = 1'b0;
          tmo_d = 10'd0;
`ifdef CSR_INIT_VERIFY_EN
          rd_d    = 1'b1;
          state_d = ST_RD;
`else
          state_d = ST_NEXT;
`endif
        end else if (tmo_q == C_TIMEOUT_LAST) begin
          wr_d    = 1'b0;
          state_d = ST_NEXT;
          if (!err_q) begin
            err_d     = 1'b1;
            err_idx_d = idx_q;
          end
        end else begin
          tmo_d = tmo_q + 10'd1;
        end
      end

`ifdef CSR_INIT_VERIFY_EN
      ST_RD: begin
        if (!mac_if.waitrequest) begin
          rd_d    = 1'b0;
          rdata_d = mac_if.readdata;
          state_d = ST_CMP;
        end else if (tmo_q == C_TIMEOUT_LAST) begin
          rd_d    = 1'b0;
          state_d = ST_NEXT;
          if (!err_q) begin
            err_d     = 1'b1;
            err_idx_d = idx_q;
          end
        end else begin
          tmo_d = tmo_q + 10'd1;
        end
      end

      ST_CMP: begin
        if ((rdata_q != tbl_data(idx_q)) && !err_q) begin
          err_d     = 1'b1;
          err_idx_d = idx_q;
        end
        state_d = ST_NEXT;
      end
`endif

      ST_NEXT: begin
        tmo_d = 10'd0;
        if (w_start) begin
          idx_d        = 2'd0;
          start_pend_d = 1'b0;
          state_d      = ST_WR;
        end else if (idx_q == 2'd3) begin
          idx_d   = 2'd0;
          state_d = ST_PASS;
        end else begin
          idx_d   = idx_q + 2'd1;
          state_d = ST_WR;
        end
        if (state_d == ST_WR) begin
          wr_d    = 1'b1;
          addr_d  = tbl_addr(idx_d);
          wdata_d = tbl_data(idx_d);
        end
      end

      ST_PASS: begin
        tmo_d = 10'd0;
        // Never cut a host transfer short: leave only when idle or completing
        if (w_start && (!w_host_busy || !mac_if.waitrequest)) begin
          state_d      = ST_WR;
          idx_d        = 2'd0;
          start_pend_d = 1'b0;
          wr_d         = 1'b1;
          addr_d       = tbl_addr(2'd0);
          wdata_d      = tbl_data(2'd0);
          err_d        = 1'b0;
          err_idx_d    = 2'd0;
        end
      end

      default: begin
        state_d = ST_NEXT;
        wr_d    = 1'b0;
        rd_d    = 1'b0;
      end
    endcase
  end

  assign mac_if.read         = w_pass ? host_if.read      : rd_q;
  assign mac_if.write        = w_pass ? host_if.write     : wr_q;
  assign mac_if.address      = w_pass ? host_if.address   : addr_q;
  assign mac_if.writedata    = w_pass ? host_if.writedata : wdata_q;
  assign host_if.readdata    = w_pass ? mac_if.readdata    : 32'd0;
  assign host_if.waitrequest = w_pass ? mac_if.waitrequest : 1'b1;

  assign init_done_o  = w_pass;
  assign init_error_o = err_q;
  assign err_index_o  = err_idx_q;

endmodule
`default_nettype wire

// File: doc/eth_mac_csr_init_arb.md
Name: eth_mac_csr_init_arb

Overview:
- Owns the 10G MAC Avalon-MM CSR port (10-bit word address, 32-bit data, waitrequest).
- After reset, or on request, it writes a fixed 4-entry configuration table into the MAC.
- It then hands the CSR port to the host as a pass-through.
- It sits between the host CSR interconnect and the MAC csr_* pins, in the csr_clk domain.

Parameters:
- ADDR0, 10'h000: CSR address of table entry 0.
- DATA0, 32'h0000_0003: write data of entry 0 (TX/RX path enable).
- ADDR1, 10'h001: CSR address of entry 1.
- DATA1, 32'd1518: write data of entry 1 (TX max frame length).
- ADDR2, 10'h002: CSR address of entry 2.
- DATA2, 32'd1518: write data of entry 2 (RX max frame length).
- ADDR3, 10'h003: CSR address of entry 3.
- DATA3, 32'hFFFF: write data of entry 3 (pause quanta).
- TIMEOUT_CYCLES, 1023: maximum cycles one MAC access may stall on waitrequest.

Ports:
- csr_clk  in  1  single clock.
- csr_rst  in  1  asynchronous, active-high reset.
- init_start  in  1  one-cycle pulse; re-runs the table.
- init_done  out  1  high while in PASS.
- init_error  out  1  sticky; set on timeout (or on readback mismatch, see Optional Feature).
- err_index  out  2  table index of the first error.
- host_read  in  1  host read request.
- host_write  in  1  host write request.
- host_address  in  10  host word address.
- host_writedata  in  32  host write data.
- host_readdata  out  32  host read data.
- host_waitrequest  out  1  host stall.
- mac_read  out  1  MAC CSR read.
- mac_write  out  1  MAC CSR write.
- mac_address  out  10  MAC CSR address.
- mac_writedata  out  32  MAC CSR write data.
- mac_readdata  in  32  MAC CSR read data.
- mac_waitrequest  in  1  MAC CSR stall.

Behaviour:
- Reset values (async assert; release takes effect on the next csr_clk edge):
  - mac_read=0, mac_write=0, mac_address=0, mac_writedata=0.
  - host_readdata=0, host_waitrequest=1.
  - init_done=0, init_error=0, err_index=0.
  - idx=0, timeout counter=0, start_pend=0.
  - State=WR.
- States: WR, (RD, CMP with the option), NEXT, PASS.
- WR:
  - mac_write=1, mac_address=ADDR[idx], mac_writedata=DATA[idx], all registered.
  - Held stable until a cycle with mac_waitrequest=0; that cycle completes the write.
  - Next state: NEXT (or RD with the option).
- Timeout:
  - A 10-bit counter increments each stalled cycle and clears on entry to every access state.
  - When it reaches TIMEOUT_CYCLES, the request is dropped (read/write=0 next cycle) and the state goes to NEXT.
  - If init_error was 0, it sets init_error=1 and err_index=idx.
- NEXT:
  - mac_read=mac_write=0 for exactly one cycle.
  - If idx==3: idx=0, go to PASS.
  - Else: idx+1, go to WR.
- Sequencer mode (any state other than PASS):
  - host_waitrequest=1; host requests are held off, never dropped.
  - Minimum sequence length, no stalls, option off: 8 cycles from reset release to init_done=1.
- PASS:
  - mac_read/write/address/writedata = host_* combinationally.
  - host_readdata = mac_readdata; host_waitrequest = mac_waitrequest (zero added latency).
  - init_done=1.
- init_start:
  - Sets start_pend in any state. A pulse during a sequence restarts the table at idx=0 after the current access completes or times out.
  - In PASS, leave to WR only on a cycle where (host_read|host_write)=0, or where mac_waitrequest=0; an in-flight host transfer is never truncated.
  - Leaving PASS clears init_done, init_error and err_index.
- Simultaneous init_start and host request in PASS: the host request is serviced first.
- host_read and host_write asserted together in PASS: forwarded unchanged; the host is responsible.

Optional Feature:
- Macro: CSR_INIT_VERIFY_EN.
- Defined:
  - After each WR the sequencer enters RD: mac_read=1, mac_address=ADDR[idx], held until mac_waitrequest=0, with the same timeout.
  - Read data is captured on that cycle; CMP (1 cycle) compares it with DATA[idx].
  - On mismatch with init_error=0: set init_error=1, err_index=idx. The sequence always continues.
  - Minimum no-stall length becomes 16 cycles.
- Undefined: RD/CMP states are absent; init_error reflects timeouts only.

Test Plan:
- Reset release, mac_waitrequest=0 always:
  - Exactly 4 writes: (0x000,3), (0x001,1518), (0x002,1518), (0x003,0xFFFF), each 1 cycle, separated by 1 idle cycle.
  - init_done=1 at cycle 8.
- mac_waitrequest held 1 for 5 cycles on entry 2: write to 0x002 held stable 6 cycles, no extra writes, init_error=0.
- mac_waitrequest stuck 1 on entry 1: after 1023 stalled cycles, init_error=1, err_index=1; entries 2 and 3 are still written; init_done=1.
- Host write (0x010, 0xA5A5) during init: host_waitrequest=1 until PASS; then forwarded in the first PASS cycle.
- In PASS, host read of 0x005 stalled 3 cycles with init_start pulsed in the 1st stall cycle: read completes with correct data; mac_write to 0x000 starts the cycle after; init_done drops.
- CSR_INIT_VERIFY_EN defined, MAC returns 1517 for 0x002: init_error=1, err_index=2; sequence completes.
